pc_fetch_unit: RTL



---
 rtl/mips_fetch_pkg.sv | 24 ++
 rtl/pc_next_calc.sv | 39 +++
 rtl/pc_fetch_unit.sv | 114 +++++++++++
 3 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS fetch stage.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned-target trap).
package mips_fetch_pkg;

    localparam int INST_W = 32;
    localparam int JIDX_W = 26;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] ALIGN_MASK       = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_REQ   = 2'd1,
        ST_ISSUE = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_t;

    // j/jal keep the top nibble of the delay-slot address.
    function automatic logic [31:0] jump_target(input logic [3:0]        pc4_hi,
                                                input logic [JIDX_W-1:0] idx);
        return {pc4_hi, idx, 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: jr > jump > taken branch > sequential.
// With FETCH_ALIGN_CHECK_EN the raw target is passed through and flagged; otherwise it is word-aligned.
module pc_next_calc
    import mips_fetch_pkg::*;
(
    input  logic [31:0]       i_pc_plus4,
    input  logic              i_jr,
    input  logic [31:0]       i_jr_target,
    input  logic              i_jump,
    input  logic [JIDX_W-1:0] i_jump_index,
    input  logic              i_branch_taken,
    input  logic [31:0]       i_branch_imm,
    output logic [31:0]       o_next_pc,
    output logic              o_misaligned
);

    logic [31:0] w_target;

    always_comb begin
        w_target = i_pc_plus4;
        if (i_jr) begin
            w_target = i_jr_target;
        end else if (i_jump) begin
            w_target = jump_target(i_pc_plus4[31:28], i_jump_index);
        end else if (i_branch_taken) begin
            // Word offset; the 32-bit add wraps silently.
            w_target = i_pc_plus4 + (i_branch_imm << 2);
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    assign o_next_pc = w_target;
`else
    assign o_next_pc = w_target & ALIGN_MASK;
`endif

    assign o_misaligned = (o_next_pc[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch FSM (BOOT -> REQ -> ISSUE) with req/ready memory handshake.
// Optional macro FETCH_ALIGN_CHECK_EN adds a sticky FAULT state for misaligned targets.
module pc_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [INST_W-1:0] inst,
    output logic              inst_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_imm,
    input  logic              jump,
    input  logic [JIDX_W-1:0] jump_index,
    input  logic              jr,
    input  logic [ADDR_W-1:0] jr_target,
    output logic              addr_fault
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [INST_W-1:0] r_inst;
    logic              r_inst_valid;
    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_next_pc;
    logic              w_misaligned;
    logic              w_fault;
    logic              w_release;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_release  = (r_state == ST_ISSUE) && !stall;

    pc_next_calc u_next (
        .i_pc_plus4     (w_pc_plus4),
        .i_jr           (jr),
        .i_jr_target    (jr_target),
        .i_jump         (jump),
        .i_jump_index   (jump_index),
        .i_branch_taken (branch_taken),
        .i_branch_imm   (branch_imm),
        .o_next_pc      (w_next_pc),
        .o_misaligned   (w_misaligned)
    );

    // Without the align check, next_pc is already aligned so this stays low.
    assign w_fault = w_misaligned;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_BOOT:  w_state_nxt = ST_REQ;
            ST_REQ:   if (imem_ready) w_state_nxt = ST_ISSUE;
            ST_ISSUE: if (!stall) w_state_nxt = w_fault ? ST_FAULT : ST_REQ;
`ifdef FETCH_ALIGN_CHECK_EN
            ST_FAULT: w_state_nxt = ST_FAULT;
`endif
            default:  w_state_nxt = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_BOOT;
            r_pc         <= RESET_PC;
            r_inst       <= '0;
            r_inst_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_REQ) && imem_ready) begin
                r_inst       <= imem_rdata;
                r_inst_valid <= 1'b1;
            end
            if (w_release) begin
                r_inst_valid <= 1'b0;
                if (!w_fault) r_pc <= w_next_pc;
            end
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_addr_fault;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr_fault <= 1'b0;
        end else if (w_release && w_fault) begin
            r_addr_fault <= 1'b1;
        end
    end

    assign addr_fault = r_addr_fault;
`else
    assign addr_fault = 1'b0;
`endif

    // Request is decoded from state so an async reset drops it immediately.
    assign imem_req   = (r_state == ST_REQ);
    assign imem_addr  = r_pc;
    assign inst       = r_inst;
    assign inst_valid = r_inst_valid;
    assign pc         = r_pc;
    assign pc_plus4   = w_pc_plus4;

endmodule
